apb_slave_regfile: RTL and testbench

//  APB responder (completer) at the far end of the AHB-to-APB bridge: a bank of
//  32-bit control/status registers with configurable wait states, pready and

---
 rtl/apb_slave_regfile_if.sv | 13 +
 rtl/apb_slave_regfile.sv | 80 ++++++++
 tb/tb_apb_slave_regfile.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB bus between the bridge (master) and a register-file completer (slave).
interface apb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a bank of 32-bit registers, programmable wait states
// and pslverr decode; address, direction and write data are captured in the setup phase.
module apb_slave_regfile #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input logic hclk,
    input logic hresetn,
    apb_if.slave bus
);
    localparam int IW = $clog2(NUM_REGS);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wd, r_prdata;
    logic        r_wr, r_pready, r_pslverr;
    logic [3:0]  r_cnt;
    logic [31:0] r_regs [NUM_REGS];
    logic        w_setup, w_load, w_wr, w_err;
    logic [31:0] w_addr, w_rd;
    logic [30:0] w_word;
    logic [IW-1:0] w_idx;
    assign w_setup = bus.psel & ~bus.penable;
    // In IDLE the transfer is still on the bus; once latched, decode from the captured copy.
    assign w_addr  = (r_state == S_IDLE) ? bus.paddr  : r_addr;
    assign w_wr    = (r_state == S_IDLE) ? bus.pwrite : r_wr;
    // Word-granular offset; bit 30 is the borrow, set when the address lies below the window.
    assign w_word  = {1'b0, w_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign w_idx   = w_word[IW-1:0];
    assign w_err   = w_word[30] | (w_addr[1:0] != 2'b00) | ({1'b0, w_word} >= 32'(NUM_REGS))
                   | (w_wr & (w_word == 31'd0));
    assign w_rd    = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = w_setup ? ((WAIT_STATES == 0) ? S_ACCESS : S_WAIT) : S_IDLE;
                w_load = w_setup && (WAIT_STATES == 0);
            end
            S_WAIT: begin
                w_next = !bus.psel ? S_IDLE : (r_cnt == 4'd1) ? S_ACCESS : S_WAIT;
                w_load = bus.psel && (r_cnt == 4'd1);
            end
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wd      <= '0;
            r_wr      <= 1'b0;
            r_cnt     <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_state   <= w_next;
            r_pready  <= w_load;
            r_pslverr <= w_load & w_err;
            r_prdata  <= (w_load & ~w_wr & ~w_err) ? w_rd : '0;
            if (r_state == S_IDLE && w_setup) begin
                r_addr <= bus.paddr;
                r_wr   <= bus.pwrite;
                r_wd   <= bus.pwdata;
                r_cnt  <= 4'(WAIT_STATES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_ACCESS && bus.psel && bus.penable && r_wr && !w_err)
                r_regs[w_idx] <= r_wd;
        end
    end
    assign bus.prdata  = r_prdata;
    assign bus.pready  = r_pready;
    assign bus.pslverr = r_pslverr;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed APB transfers against a zero-wait and a two-wait-state register file.
module tb_apb_slave_regfile;
    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        t_sel = 1'b0;
    logic        t_psel = 1'b0;
    logic        t_penable = 1'b0;
    logic        t_pwrite = 1'b0;
    logic [31:0] t_paddr = '0;
    logic [31:0] t_pwdata = '0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] rd;
    logic        err;
    int          lat;
    apb_if b0();
    apb_if b1();
    assign b0.psel    = t_psel & ~t_sel;
    assign b1.psel    = t_psel & t_sel;
    assign b0.penable = t_penable;
    assign b1.penable = t_penable;
    assign b0.pwrite  = t_pwrite;
    assign b1.pwrite  = t_pwrite;
    assign b0.paddr   = t_paddr;
    assign b1.paddr   = t_paddr;
    assign b0.pwdata  = t_pwdata;
    assign b1.pwdata  = t_pwdata;
    wire        o_pready  = t_sel ? b1.pready  : b0.pready;
    wire        o_pslverr = t_sel ? b1.pslverr : b0.pslverr;
    wire [31:0] o_prdata  = t_sel ? b1.prdata  : b0.prdata;
    apb_slave_regfile u0 (.hclk(hclk), .hresetn(hresetn), .bus(b0.slave));
    apb_slave_regfile #(.WAIT_STATES(2)) u1 (.hclk(hclk), .hresetn(hresetn), .bus(b1.slave));
    always #5 hclk = ~hclk;

    // Called at a falling edge; the access phase scrambles paddr/pwdata to prove setup-phase latching.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic keep,
                        output logic [31:0] q, output logic e, output int l);
        t_psel = 1'b1;
        t_penable = 1'b0;
        t_pwrite = wr;
        t_paddr = addr;
        t_pwdata = wd;
        @(negedge hclk);
        t_penable = 1'b1;
        t_paddr = 32'hFFFF_FFFC;
        t_pwdata = 32'h0;
        l = 1;
        while (o_pready !== 1'b1 && l < 20) begin
            @(negedge hclk);
            l++;
        end
        q = o_prdata;
        e = o_pslverr;
        @(negedge hclk);
        if (!keep) begin
            t_psel = 1'b0;
            t_penable = 1'b0;
        end
    endtask

    task automatic test_reset;
        hresetn = 1'b0;
        repeat (3) @(negedge hclk);
        vectors++;
        if ({b0.pready, b0.pslverr, b1.pready, b1.pslverr} !== 4'b0) begin
            $display("FAIL reset_flags got %b want 0000", {b0.pready, b0.pslverr, b1.pready, b1.pslverr});
            miscompares++;
        end
        vectors++;
        if ({b0.prdata, b1.prdata} !== 64'h0) begin
            $display("FAIL reset_prdata got %h/%h want 0", b0.prdata, b1.prdata);
            miscompares++;
        end
        hresetn = 1'b1;
        @(negedge hclk);
        xfer(1'b0, 32'h08, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (lat !== 1) begin $display("FAIL rd08_latency got %0d want 1", lat); miscompares++; end
        vectors++;
        if (rd !== 32'h0) begin $display("FAIL rd08_data got %h want 0", rd); miscompares++; end
        vectors++;
        if (err !== 1'b0) begin $display("FAIL rd08_err got %b want 0", err); miscompares++; end
    endtask

    task automatic test_write_read;
        xfer(1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0, rd, err, lat);
        vectors++;
        if (err !== 1'b0 || lat !== 1) begin
            $display("FAIL wr04_resp got err=%b lat=%0d want err=0 lat=1", err, lat);
            miscompares++;
        end
        xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin $display("FAIL rd04_data got %h want deadbeef", rd); miscompares++; end
    endtask

    task automatic test_id;
        xfer(1'b0, 32'h00, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'hA5B0_0001 || err !== 1'b0) begin
            $display("FAIL rd_id got %h err=%b want a5b00001 err=0", rd, err);
            miscompares++;
        end
        xfer(1'b1, 32'h00, 32'h1234_0000, 1'b0, rd, err, lat);
        vectors++;
        if (err !== 1'b1 || lat !== 1) begin
            $display("FAIL wr_id_err got err=%b lat=%0d want err=1 lat=1", err, lat);
            miscompares++;
        end
        xfer(1'b0, 32'h00, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'hA5B0_0001) begin $display("FAIL rerd_id got %h want a5b00001", rd); miscompares++; end
    endtask

    task automatic test_errors;
        xfer(1'b0, 32'h20, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (err !== 1'b1 || lat !== 1) begin
            $display("FAIL rd20_err got err=%b lat=%0d want err=1 lat=1", err, lat);
            miscompares++;
        end
        vectors++;
        if (rd !== 32'h0) begin $display("FAIL rd20_data got %h want 0", rd); miscompares++; end
        xfer(1'b1, 32'h05, 32'h5555_5555, 1'b0, rd, err, lat);
        vectors++;
        if (err !== 1'b1) begin $display("FAIL wr05_err got %b want 1", err); miscompares++; end
        xfer(1'b1, 32'h1C, 32'h0BAD_0BAD, 1'b0, rd, err, lat);
        xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin $display("FAIL rd04_after_err got %h want deadbeef", rd); miscompares++; end
        xfer(1'b0, 32'h08, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'h0) begin $display("FAIL rd08_after_err got %h want 0", rd); miscompares++; end
        t_psel = 1'b1;
        t_penable = 1'b1;
        t_paddr = 32'h04;
        repeat (3) begin
            @(negedge hclk);
            vectors++;
            if (o_pready !== 1'b0) begin $display("FAIL stray_penable got pready=%b want 0", o_pready); miscompares++; end
        end
        t_psel = 1'b0;
        t_penable = 1'b0;
        @(negedge hclk);
    endtask

    task automatic test_back_to_back;
        xfer(1'b1, 32'h18, 32'h1111_2222, 1'b1, rd, err, lat);
        xfer(1'b0, 32'h18, 32'h0, 1'b1, rd, err, lat);
        vectors++;
        if (rd !== 32'h1111_2222 || lat !== 1) begin
            $display("FAIL b2b_rd18 got %h lat=%0d want 11112222 lat=1", rd, lat);
            miscompares++;
        end
        xfer(1'b0, 32'h1C, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'h0BAD_0BAD) begin $display("FAIL b2b_rd1c got %h want 0bad0bad", rd); miscompares++; end
    endtask

    task automatic test_wait_states;
        t_sel = 1'b1;
        xfer(1'b1, 32'h0C, 32'h1234_5678, 1'b0, rd, err, lat);
        vectors++;
        if (lat !== 3 || err !== 1'b0) begin
            $display("FAIL ws_wr0c got lat=%0d err=%b want lat=3 err=0", lat, err);
            miscompares++;
        end
        xfer(1'b0, 32'h0C, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'h1234_5678 || lat !== 3) begin
            $display("FAIL ws_rd0c got %h lat=%0d want 12345678 lat=3", rd, lat);
            miscompares++;
        end
        t_psel = 1'b1;
        t_penable = 1'b0;
        t_pwrite = 1'b1;
        t_paddr = 32'h0C;
        t_pwdata = 32'hFFFF_0000;
        @(negedge hclk);
        t_penable = 1'b1;
        @(negedge hclk);
        t_psel = 1'b0;
        t_penable = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            vectors++;
            if (o_pready !== 1'b0) begin $display("FAIL abort_pready got %b want 0", o_pready); miscompares++; end
        end
        xfer(1'b0, 32'h0C, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'h1234_5678 || lat !== 3) begin
            $display("FAIL abort_rd0c got %h lat=%0d want 12345678 lat=3", rd, lat);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid;
        t_sel = 1'b1;
        xfer(1'b1, 32'h08, 32'h5, 1'b0, rd, err, lat);
        xfer(1'b0, 32'h08, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'h5) begin $display("FAIL rm_rd08_pre got %h want 5", rd); miscompares++; end
        t_psel = 1'b1;
        t_penable = 1'b0;
        t_pwrite = 1'b1;
        t_paddr = 32'h08;
        t_pwdata = 32'h7;
        @(negedge hclk);
        t_penable = 1'b1;
        hresetn = 1'b0;
        #1;
        vectors++;
        if ({o_pready, o_pslverr} !== 2'b00 || o_prdata !== 32'h0) begin
            $display("FAIL rm_outputs got pready=%b pslverr=%b prdata=%h want 0", o_pready, o_pslverr, o_prdata);
            miscompares++;
        end
        @(negedge hclk);
        t_psel = 1'b0;
        t_penable = 1'b0;
        hresetn = 1'b1;
        @(negedge hclk);
        xfer(1'b0, 32'h08, 32'h0, 1'b0, rd, err, lat);
        vectors++;
        if (rd !== 32'h0 || lat !== 3) begin
            $display("FAIL rm_rd08_post got %h lat=%0d want 0 lat=3", rd, lat);
            miscompares++;
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_id;
        test_errors;
        test_back_to_back;
        test_wait_states;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
